// File: rtl/frame_buf_pkg.sv
// Shared definitions for the multi-buffer frame buffer.
//   wr_state_t : writer FSM encoding (idle / filling a frame / all buffers full)
//   rd_state_t : reader FSM encoding (idle / mid-frame)
//   frame_len(), num_bufs() : derived sizes from the log2 parameters
package frame_buf_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_FILL    = 2'd1,
        WR_BLOCKED = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    function automatic int frame_len(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int num_bufs(input int buf_idx_width);
        return 1 << buf_idx_width;
    endfunction

endpackage

// File: rtl/frame_buf_multi_data_mem.sv
// data_mem: simple dual-port storage, one write port and one registered read port.
//   clk, reset : clock; reset clears only the read data register
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates one cycle after re and holds otherwise
module data_mem #(
    parameter int DW = 24,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_buf_multi.sv
// frame_buf_multi: ring of 2^BUF_IDX_WIDTH frame buffers, each 2^ADDR_WIDTH words.
// Writer fills frames in order, reader drains completed frames FIFO order.
//   clk, reset          : single clock, synchronous active-high reset
//   wr_en_in, data_in   : write strobe / data; wr_abort drops the partial frame
//   wr_rdy              : a free buffer exists
//   wr_frame_done       : pulse the cycle after a frame's last word is written
//   rd_en_in            : read strobe; data_out/rd_valid follow one cycle later
//   rd_frame_done       : aligned with the rd_valid of a frame's last word
//   rd_rdy, frames_ready: complete-frame availability / count
//   overflow, underflow : sticky misuse flags, cleared only by reset
module frame_buf_multi
    import frame_buf_pkg::*;
#(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDR_WIDTH    = 3,
    parameter int BUF_IDX_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    wr_abort,
    output logic                    wr_rdy,
    output logic                    wr_frame_done,
    input  logic                    rd_en_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    rd_frame_done,
    output logic                    rd_rdy,
    output logic [BUF_IDX_WIDTH:0]  frames_ready,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int NUM_BUFS = num_bufs(BUF_IDX_WIDTH);
    localparam logic [BUF_IDX_WIDTH:0] FULL_CNT  = (BUF_IDX_WIDTH+1)'(NUM_BUFS);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(frame_len(ADDR_WIDTH) - 1);

    logic [BUF_IDX_WIDTH-1:0] wr_buf, rd_buf;
    logic [ADDR_WIDTH-1:0]    wr_addr, rd_addr;
    logic [BUF_IDX_WIDTH:0]   cnt, cnt_d;
    wr_state_t                wr_state, wr_state_d;
    rd_state_t                rd_state, rd_state_d;
    logic                     wr_fd_q, rd_vld_q, rd_fd_q, ovf_q, unf_q;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    logic wr_free, rd_avail, wr_accept, rd_accept, frame_cmpl, frame_free;

    // The buffer under read stays counted until its last word goes out, so
    // wr_free alone keeps the writer off unread data.
    assign wr_free    = (cnt != FULL_CNT);
    assign rd_avail   = (cnt != '0);
    assign wr_accept  = wr_en_in & wr_free & ~wr_abort;
    assign rd_accept  = rd_en_in & rd_avail;
    assign frame_cmpl = wr_accept & (wr_addr == LAST_ADDR);
    assign frame_free = rd_accept & (rd_addr == LAST_ADDR);

    always_comb begin
        cnt_d = cnt;
        case ({frame_cmpl, frame_free})
            2'b10:   cnt_d = cnt + 1'b1;
            2'b01:   cnt_d = cnt - 1'b1;
            default: cnt_d = cnt;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state;
        case (wr_state)
            WR_IDLE:    if (wr_accept && !frame_cmpl) wr_state_d = WR_FILL;
            WR_FILL:    if (wr_abort || frame_cmpl)   wr_state_d = WR_IDLE;
            WR_BLOCKED: if (frame_free)               wr_state_d = WR_IDLE;
            default:                                  wr_state_d = WR_IDLE;
        endcase
        // State tracks the wr_rdy the writer will see next cycle.
        if (cnt_d == FULL_CNT)
            wr_state_d = WR_BLOCKED;
    end

    always_comb begin
        rd_state_d = rd_state;
        case (rd_state)
            RD_IDLE: if (rd_accept && !frame_free) rd_state_d = RD_READ;
            RD_READ: if (frame_free)               rd_state_d = RD_IDLE;
            default:                               rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_buf   <= '0;
            wr_addr  <= '0;
            rd_buf   <= '0;
            rd_addr  <= '0;
            cnt      <= '0;
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            wr_fd_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_fd_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_abort)
                wr_addr <= '0;
            else if (wr_accept) begin
                wr_addr <= wr_addr + 1'b1;
                if (frame_cmpl)
                    wr_buf <= wr_buf + 1'b1;
            end
            if (rd_accept) begin
                rd_addr <= rd_addr + 1'b1;
                if (frame_free)
                    rd_buf <= rd_buf + 1'b1;
            end
            cnt      <= cnt_d;
            wr_state <= wr_state_d;
            rd_state <= rd_state_d;
            wr_fd_q  <= frame_cmpl;
            rd_vld_q <= rd_accept;
            rd_fd_q  <= frame_free;
            // Abort takes precedence, so an aborted strobe is not an overflow.
            if (wr_en_in && !wr_abort && !wr_free)
                ovf_q <= 1'b1;
            if (rd_en_in && !rd_avail)
                unf_q <= 1'b1;
        end
    end

    data_mem #(
        .DW(DATA_WIDTH),
        .AW(ADDR_WIDTH + BUF_IDX_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_accept & ~reset),
        .waddr ({wr_buf, wr_addr}),
        .wdata (data_in),
        .re    (rd_accept & ~reset),
        .raddr ({rd_buf, rd_addr}),
        .rdata (mem_rdata)
    );

    // Every output reads as 0 for as long as reset is held.
    assign wr_rdy        = ~reset & wr_free;
    assign rd_rdy        = ~reset & rd_avail;
    assign frames_ready  = reset ? '0 : cnt;
    assign wr_frame_done = ~reset & wr_fd_q;
    assign rd_valid      = ~reset & rd_vld_q;
    assign rd_frame_done = ~reset & rd_fd_q;
    assign overflow      = ~reset & ovf_q;
    assign underflow     = ~reset & unf_q;
    assign data_out      = reset ? '0 : mem_rdata;

endmodule

// File: tb/tb_frame_buf_multi.sv
module tb_frame_buf_multi;

    localparam int DW = 24;
    localparam int FL = 8;
    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          reset, wr_en_in, wr_abort, rd_en_in;
    logic [DW-1:0] data_in, data_out;
    logic          wr_rdy, wr_frame_done, rd_valid, rd_frame_done, rd_rdy;
    logic [1:0]    frames_ready;
    logic          overflow, underflow;

    always #5 clk = ~clk;

    frame_buf_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .BUF_IDX_WIDTH(1)) dut (
        .clk(clk), .reset(reset),
        .wr_en_in(wr_en_in), .data_in(data_in), .wr_abort(wr_abort),
        .wr_rdy(wr_rdy), .wr_frame_done(wr_frame_done),
        .rd_en_in(rd_en_in), .data_out(data_out), .rd_valid(rd_valid),
        .rd_frame_done(rd_frame_done), .rd_rdy(rd_rdy),
        .frames_ready(frames_ready), .overflow(overflow), .underflow(underflow)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference model: completed-frame words as a FIFO, plus the partial frame.
    int            m_fr;
    int            m_rpos;
    logic [DW-1:0] m_full[$];
    logic [DW-1:0] m_part[$];
    logic          m_vld, m_rfd, m_wfd, m_ovf, m_unf;
    logic [DW-1:0] m_dat;

    task automatic model_clear();
        m_fr = 0; m_rpos = 0;
        m_full.delete(); m_part.delete();
        m_vld = 0; m_rfd = 0; m_wfd = 0; m_ovf = 0; m_unf = 0; m_dat = '0;
    endtask

    task automatic step(input logic rst, input logic we, input logic ab,
                        input logic re, input logic [DW-1:0] d);
        bit wrdy, rrdy;
        int done, freed;
        reset = rst; wr_en_in = we; wr_abort = ab; rd_en_in = re; data_in = d;
        @(posedge clk);
        if (rst) model_clear();
        else begin
            wrdy = (m_fr < NB); rrdy = (m_fr > 0);
            done = 0; freed = 0;
            m_vld = 0; m_rfd = 0; m_wfd = 0;
            if (re) begin
                if (rrdy) begin
                    m_dat = m_full.pop_front();
                    m_vld = 1;
                    m_rpos++;
                    if (m_rpos == FL) begin m_rpos = 0; m_rfd = 1; freed = 1; end
                end else m_unf = 1;
            end
            if (ab) m_part.delete();
            else if (we) begin
                if (wrdy) begin
                    m_part.push_back(d);
                    if (m_part.size() == FL) begin
                        for (int k = 0; k < FL; k++) m_full.push_back(m_part[k]);
                        m_part.delete();
                        m_wfd = 1; done = 1;
                    end
                end else m_ovf = 1;
            end
            m_fr += done - freed;
        end
        #1;
        chk("data_out",      data_out,      m_dat);
        chk("rd_valid",      rd_valid,      m_vld);
        chk("rd_frame_done", rd_frame_done, m_rfd);
        chk("wr_frame_done", wr_frame_done, m_wfd);
        chk("frames_ready",  frames_ready,  rst ? 0 : m_fr);
        chk("wr_rdy",        wr_rdy,        rst ? 0 : (m_fr < NB));
        chk("rd_rdy",        rd_rdy,        rst ? 0 : (m_fr > 0));
        chk("overflow",      overflow,      m_ovf);
        chk("underflow",     underflow,     m_unf);
    endtask

    typedef struct {
        logic rst, we, ab, re;
        logic [DW-1:0] d;
        int   e_fr;
        logic e_wrdy, e_rrdy, e_wfd, e_rfd, e_vld;
        logic [DW-1:0] e_dat;
    } vec_t;

    vec_t tbl[18];

    initial begin
        reset = 1; wr_en_in = 0; wr_abort = 0; rd_en_in = 0; data_in = '0;
        model_clear();

        // Basic frame: reset, write 1..8, read 1..8, one idle cycle.
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{0, 1, 0, 0, DW'(i), (i == 8) ? 1 : 0, 1, i == 8, i == 8, 0, 0, 0};
        for (int j = 1; j <= 8; j++)
            tbl[8+j] = '{0, 0, 0, 1, 0, (j == 8) ? 0 : 1, 1, j != 8, 0, j == 8, 1, DW'(j)};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 24'd8};

        for (int r = 0; r < 18; r++) begin
            step(tbl[r].rst, tbl[r].we, tbl[r].ab, tbl[r].re, tbl[r].d);
            chk($sformatf("tbl%0d_frames", r), frames_ready,  tbl[r].e_fr);
            chk($sformatf("tbl%0d_wr_rdy", r), wr_rdy,        tbl[r].e_wrdy);
            chk($sformatf("tbl%0d_rd_rdy", r), rd_rdy,        tbl[r].e_rrdy);
            chk($sformatf("tbl%0d_wfd", r),    wr_frame_done, tbl[r].e_wfd);
            chk($sformatf("tbl%0d_rfd", r),    rd_frame_done, tbl[r].e_rfd);
            chk($sformatf("tbl%0d_vld", r),    rd_valid,      tbl[r].e_vld);
            chk($sformatf("tbl%0d_data", r),   data_out,      tbl[r].e_dat);
        end

        // Overflow: three frames back-to-back with two buffers.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3*FL; i++) begin
            step(0, 1, 0, 0, DW'(16*(i/FL) + i%FL));
            if (i == 2*FL-1) begin
                chk("ovf_wr_rdy_full", wr_rdy, 0);
                chk("ovf_frames_full", frames_ready, 2);
            end
        end
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < FL; i++) begin
            step(0, 0, 0, 1, 0);
            chk("ovf_rd_data", data_out, i);
            chk("ovf_wr_rdy_drain", wr_rdy, i == FL-1);
        end
        for (int i = 0; i < FL; i++) begin
            step(0, 0, 0, 1, 0);
            chk("ovf_rd_data2", data_out, 16 + i);
        end
        chk("ovf_sticky", overflow, 1);

        // Underflow.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("unf_valid", rd_valid, 0);
        chk("unf_flag", underflow, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("unf_sticky", underflow, 1);
        step(1, 0, 0, 0, 0);
        chk("unf_cleared", underflow, 0);

        // Abort a 5-word partial frame (abort also wins over a write).
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, DW'(24'h550 + i));
        step(0, 1, 1, 0, 24'h5FF);
        chk("abort_no_ovf", overflow, 0);
        for (int i = 0; i < FL; i++) step(0, 1, 0, 0, DW'(24'hA0 + i));
        chk("abort_frames", frames_ready, 1);
        for (int i = 0; i < FL; i++) begin
            step(0, 0, 0, 1, 0);
            chk("abort_rd_data", data_out, 24'hA0 + i);
        end

        // Writer completes a frame while the reader frees one.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < FL; i++) step(0, 1, 0, 0, DW'(24'h100 + i));
        for (int i = 0; i < FL-1; i++) step(0, 1, 0, 1, DW'(24'h200 + i));
        step(0, 1, 0, 1, DW'(24'h200 + FL-1));
        chk("sim_frames", frames_ready, 1);
        chk("sim_wfd", wr_frame_done, 1);
        chk("sim_rfd", rd_frame_done, 1);
        chk("sim_data", data_out, 24'h100 + FL-1);

        // Reset mid-write, then mid-read, then a clean frame from buffer 0.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, DW'(24'h300 + i));
        step(1, 1, 0, 1, 24'h3FF);
        chk("rstw_frames", frames_ready, 0);
        chk("rstw_wr_rdy", wr_rdy, 0);
        for (int i = 0; i < FL; i++) step(0, 1, 0, 0, DW'(24'h400 + i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("rstr_valid", rd_valid, 0);
        chk("rstr_data", data_out, 0);
        for (int i = 0; i < FL; i++) step(0, 1, 0, 0, DW'(24'hC0 + i));
        chk("rst_frames", frames_ready, 1);
        for (int i = 0; i < FL; i++) begin
            step(0, 0, 0, 1, 0);
            chk("rst_rd_data", data_out, 24'hC0 + i);
        end

        // Randomized traffic against the model, alternating write- and read-heavy phases.
        for (int c = 0; c < 3000; c++) begin
            logic we, re, ab, rst;
            bit wheavy;
            wheavy = ((c / 300) % 2) == 0;
            we  = wheavy ? ($urandom % 4 != 0) : ($urandom % 3 == 0);
            re  = wheavy ? ($urandom % 3 == 0) : ($urandom % 4 != 0);
            ab  = ($urandom % 60 == 0);
            rst = ($urandom % 700 == 0);
            step(rst, we, ab, re, DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_buf_multi.md
Name: frame_buf_multi

Overview:
- N-buffer, single-clock frame buffer; successor to the single-buffer frame_buf.
- Writer fills fixed-length frames of 2^ADDR_WIDTH words into a ring of 2^BUF_IDX_WIDTH buffers. Reader drains completed frames in FIFO order.
- Provides flow control, partial-frame abort, sticky overflow/underflow flags and a ready-frame count.
- Sits between the pixel source and the display/readout path.

Parameters:
DATA_WIDTH, 24, word width
ADDR_WIDTH, 3, log2 words per frame (frame length FRAME_LEN = 2^ADDR_WIDTH)
BUF_IDX_WIDTH, 1, log2 buffer count (NUM_BUFS = 2^BUF_IDX_WIDTH, derived, not overridable)

Ports:
clk  in  1  sole clock, all logic on posedge
reset  in  1  synchronous, active-high
wr_en_in  in  1  write strobe, one word per cycle
data_in  in  DATA_WIDTH  write data
wr_abort  in  1  discard current partial frame
wr_rdy  out  1  a free buffer exists; writes are accepted
wr_frame_done  out  1  one-cycle pulse, frame completed
rd_en_in  in  1  read strobe, one word per cycle
data_out  out  DATA_WIDTH  read data
rd_valid  out  1  data_out valid
rd_frame_done  out  1  one-cycle pulse, last word of a frame presented
rd_rdy  out  1  at least one complete frame is available
frames_ready  out  BUF_IDX_WIDTH+1  number of complete, unfreed frames (0..NUM_BUFS)
overflow  out  1  sticky: write attempted while wr_rdy=0
underflow  out  1  sticky: read attempted while rd_rdy=0

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - wr_buf, wr_addr, rd_buf, rd_addr, frames_ready = 0.
  - All outputs 0 while reset=1, including wr_rdy. Inputs are ignored.
  - Reset mid-frame discards all content.
- Memory: one data_mem of depth NUM_BUFS*FRAME_LEN, address {buf_idx, word_addr}, one-cycle registered read.
- wr_rdy = (frames_ready < NUM_BUFS). rd_rdy = (frames_ready != 0).
- Write accept = wr_en_in & wr_rdy & ~wr_abort.
  - Word goes to {wr_buf, wr_addr}; wr_addr increments.
  - On the word at wr_addr = FRAME_LEN-1: wr_addr wraps to 0, wr_buf increments mod NUM_BUFS, frame counted, wr_frame_done=1 next cycle.
- wr_en_in & ~wr_rdy: word dropped, overflow set; stays set until reset.
- wr_abort: wr_addr <= 0 and wr_buf unchanged. Abort wins over a same-cycle wr_en_in (word dropped, no overflow).
- Read accept = rd_en_in & rd_rdy.
  - Reads {rd_buf, rd_addr}; data_out and rd_valid=1 appear next cycle.
  - rd_valid=0 in cycles with no accepted read; data_out holds its last value.
- On accepted read of rd_addr = FRAME_LEN-1: rd_addr wraps to 0, rd_buf increments mod NUM_BUFS, frame freed, rd_frame_done=1 aligned with that word's rd_valid.
- rd_en_in & ~rd_rdy: no read, underflow set (sticky).
- frames_ready update per cycle:
  - +1 on frame complete, -1 on frame free.
  - Both in the same cycle: unchanged.
  - Never exceeds NUM_BUFS and never goes below 0, guaranteed by the accept conditions.
- The buffer being read stays counted until freed, so the writer never overwrites unread data. Reader only touches counted buffers: no read/write hazard.
- Writer FSM, registered state:
  - WR_IDLE (wr_addr=0) -> WR_FILL on accept.
  - WR_FILL -> WR_IDLE on last word or abort.
  - WR_FILL/WR_IDLE -> WR_BLOCKED when wr_rdy=0.
  - WR_BLOCKED -> WR_IDLE when a frame is freed.
- Reader FSM:
  - RD_IDLE -> RD_READ on first accepted read.
  - RD_READ -> RD_IDLE after the last word.
  - Gaps in rd_en_in hold state and address.

Decomposition:
- Shared package frame_buf_pkg: writer/reader state encodings (WR_IDLE, WR_FILL, WR_BLOCKED, RD_IDLE, RD_READ) and the derived NUM_BUFS/FRAME_LEN constants.
- Sub-module: existing data_mem instanced with ADDR_WIDTH+BUF_IDX_WIDTH address bits; no new sub-module.

Test Plan:
- Reset, then write 8 words 0x000001..0x000008 -> wr_frame_done pulse after 8th, frames_ready=1, rd_rdy=1. Read 8 -> data_out 0x000001..0x000008 one cycle after each accepted read, rd_frame_done with 0x000008, frames_ready=0.
- Write 3 frames back-to-back, no reads (2 bufs) -> wr_rdy=0 after frame 2, frames_ready=2, frame-3 words dropped, overflow=1. Then read one frame -> wr_rdy=1 the cycle after its last read.
- Read with frames_ready=0 -> rd_valid stays 0, underflow=1. Sticky until reset.
- Write 5 words, assert wr_abort, then write 8 words 0xA0..0xA7 -> frames_ready=1, readback 0xA0..0xA7, no trace of the first 5.
- frames_ready=1, writer finishing its last word on the same cycle the reader takes its last word -> frames_ready remains 1; wr_frame_done and rd_frame_done both pulse.
- Reset asserted mid-write (word 4) and mid-read -> next cycle all outputs 0, flags cleared; a subsequent full frame reads back correctly from buffer 0.
